// File: rtl/mini_src_pkg.sv
// Shared opcodes, ALU codes, bus selects, FSM states and the control vector
// for the Mini SRC hardwired control unit.
package mini_src_pkg;

  localparam int unsigned OPW   = 5;
  localparam int unsigned ALUW  = 4;
  localparam int unsigned BSW   = 5;
  localparam int unsigned WORDW = 32;
  localparam int unsigned WAITW = 4;

  localparam logic [OPW-1:0] OP_LD   = 5'b00000;
  localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPW-1:0] OP_ST   = 5'b00010;
  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_BR   = 5'b10010;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11001;
  localparam logic [OPW-1:0] OP_HALT = 5'b11010;

  localparam logic [ALUW-1:0] ALU_NONE = 4'b0000;
  localparam logic [ALUW-1:0] ALU_ADD  = 4'b0011;
  localparam logic [ALUW-1:0] ALU_SUB  = 4'b0100;
  localparam logic [ALUW-1:0] ALU_AND  = 4'b0101;
  localparam logic [ALUW-1:0] ALU_OR   = 4'b0110;

  localparam logic [BSW-1:0] BUS_NONE = 5'b00000;
  localparam logic [BSW-1:0] BUS_GPR  = 5'b00000;
  localparam logic [BSW-1:0] BUS_ZLO  = 5'b10011;
  localparam logic [BSW-1:0] BUS_PC   = 5'b10100;
  localparam logic [BSW-1:0] BUS_MDR  = 5'b10101;
  localparam logic [BSW-1:0] BUS_C    = 5'b11000;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T1W, S_T2, S_DEC,
    S_E3, S_E4, S_E5, S_E6, S_E7, S_E8, S_HALT
  } state_t;

  typedef struct packed {
    logic            inc_pc;
    logic            e_pc;
    logic            e_ir;
    logic            e_y;
    logic            e_z;
    logic            e_mdr;
    logic            e_mar;
    logic            e_con_ff;
    logic            ram_read;
    logic            ram_write;
    logic            mdr_read;
    logic [ALUW-1:0] alu_op;
    logic [BSW-1:0]  bus_sel;
    logic            gra;
    logic            grb;
    logic            grc;
    logic            e_rin;
    logic            e_rout;
    logic            ba_out;
    logic            imm_sel;
    logic            halted;
    logic            illegal;
  } ctrl_t;

  function automatic logic is_alu(input logic [OPW-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  function automatic logic is_mem(input logic [OPW-1:0] op);
    return (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
  endfunction

endpackage

// File: rtl/mini_src_ctrl_decode.sv
// Combinational Moore decode of (state, opcode, con_ff) into the datapath
// control vector; every control defaults to 0 / NONE.
module mini_src_ctrl_decode
  import mini_src_pkg::*;
(
  input  state_t         i_state,
  input  logic [OPW-1:0] i_opcode,
  input  logic           i_con_ff,
  output ctrl_t          o_ctrl_c
);

  always_comb begin
    o_ctrl_c = ctrl_t'('0);
    o_ctrl_c.alu_op  = ALU_NONE;
    o_ctrl_c.bus_sel = BUS_NONE;
    case (i_state)
      S_T0: begin
        o_ctrl_c.bus_sel = BUS_PC;
        o_ctrl_c.e_mar   = 1'b1;
        o_ctrl_c.inc_pc  = 1'b1;
      end
      S_T1:  o_ctrl_c.ram_read = 1'b1;
      S_T1W: begin
        o_ctrl_c.mdr_read = 1'b1;
        o_ctrl_c.e_mdr    = 1'b1;
      end
      S_T2: begin
        o_ctrl_c.bus_sel = BUS_MDR;
        o_ctrl_c.e_ir    = 1'b1;
      end
      S_DEC: o_ctrl_c.illegal = !(is_mem(i_opcode) || is_alu(i_opcode) ||
                                  i_opcode == OP_BR || i_opcode == OP_NOP ||
                                  i_opcode == OP_HALT);
      S_E3: begin
        o_ctrl_c.bus_sel = BUS_GPR;
        if (i_opcode == OP_BR) begin
          o_ctrl_c.gra      = 1'b1;
          o_ctrl_c.e_rout   = 1'b1;
          o_ctrl_c.e_con_ff = 1'b1;
        end else begin
          // ld/ldi/st use BAout so R0 as base reads as zero
          o_ctrl_c.grb    = 1'b1;
          o_ctrl_c.e_rout = is_alu(i_opcode);
          o_ctrl_c.ba_out = !is_alu(i_opcode);
          o_ctrl_c.e_y    = 1'b1;
        end
      end
      S_E4: begin
        if (i_opcode == OP_BR) begin
          o_ctrl_c.bus_sel = BUS_PC;
          o_ctrl_c.e_y     = 1'b1;
        end else if (is_alu(i_opcode)) begin
          o_ctrl_c.bus_sel = BUS_GPR;
          o_ctrl_c.grc     = 1'b1;
          o_ctrl_c.e_rout  = 1'b1;
          o_ctrl_c.alu_op  = i_opcode[ALUW-1:0];
          o_ctrl_c.e_z     = 1'b1;
        end else begin
          o_ctrl_c.imm_sel = 1'b1;
          o_ctrl_c.alu_op  = ALU_ADD;
          o_ctrl_c.e_z     = 1'b1;
        end
      end
      S_E5: begin
        if (i_opcode == OP_BR) begin
          o_ctrl_c.imm_sel = 1'b1;
          o_ctrl_c.alu_op  = ALU_ADD;
          o_ctrl_c.e_z     = 1'b1;
        end else if (is_alu(i_opcode) || i_opcode == OP_LDI) begin
          o_ctrl_c.bus_sel = BUS_ZLO;
          o_ctrl_c.gra     = 1'b1;
          o_ctrl_c.e_rin   = 1'b1;
        end else begin
          o_ctrl_c.bus_sel = BUS_ZLO;
          o_ctrl_c.e_mar   = 1'b1;
        end
      end
      S_E6: begin
        if (i_opcode == OP_BR) begin
          o_ctrl_c.bus_sel = BUS_ZLO;
          o_ctrl_c.e_pc    = i_con_ff;
        end else if (i_opcode == OP_ST) begin
          o_ctrl_c.bus_sel = BUS_GPR;
          o_ctrl_c.gra     = 1'b1;
          o_ctrl_c.e_rout  = 1'b1;
          o_ctrl_c.e_mdr   = 1'b1;
        end else begin
          o_ctrl_c.ram_read = 1'b1;
        end
      end
      S_E7: begin
        if (i_opcode == OP_ST) begin
          o_ctrl_c.ram_write = 1'b1;
        end else begin
          o_ctrl_c.mdr_read = 1'b1;
          o_ctrl_c.e_mdr    = 1'b1;
        end
      end
      S_E8: begin
        o_ctrl_c.bus_sel = BUS_MDR;
        o_ctrl_c.gra     = 1'b1;
        o_ctrl_c.e_rin   = 1'b1;
      end
      S_HALT: o_ctrl_c.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mini_src_control_unit.sv
// Mini SRC hardwired control unit: state register, post-reset wait counter and
// next-state sequencing; control outputs come from mini_src_ctrl_decode.
module mini_src_control_unit
  import mini_src_pkg::*;
#(
  parameter int unsigned RESET_PC_WAIT = 0
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              run,
  input  logic [WORDW-1:0]  ir,
  input  logic              con_ff,
  output logic              incPC,
  output logic              e_PC,
  output logic              e_IR,
  output logic              e_Y,
  output logic              e_Z,
  output logic              e_MDR,
  output logic              e_MAR,
  output logic              e_CON_FF,
  output logic              e_HI,
  output logic              e_LO,
  output logic              e_RA,
  output logic              e_GP,
  output logic              e_OutPort,
  output logic              e_InPort,
  output logic              ram_read,
  output logic              ram_write,
  output logic              MDR_read,
  output logic [ALUW-1:0]   ALU_op,
  output logic [BSW-1:0]    BusDataSelect,
  output logic              Gra,
  output logic              Grb,
  output logic              Grc,
  output logic              e_Rin,
  output logic              e_Rout,
  output logic              BAout,
  output logic              imm_sel,
  output logic              halted,
  output logic              illegal
);

  state_t           r_state;
  logic [WAITW-1:0] r_wait;
  logic [OPW-1:0]   w_opcode;
  logic             w_unused_ir;
  ctrl_t            w_ctrl;

  assign w_opcode    = ir[31:27];
  assign w_unused_ir = ^ir[26:0];

  // Sequencer; run is only looked at once the wait counter has drained
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state <= S_IDLE;
      r_wait  <= WAITW'(RESET_PC_WAIT);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_wait != '0)  r_wait  <= r_wait - WAITW'(1);
          else if (run)      r_state <= S_T0;
        end
        S_T0:  r_state <= S_T1;
        S_T1:  r_state <= S_T1W;
        S_T1W: r_state <= S_T2;
        S_T2:  r_state <= S_DEC;
        S_DEC: begin
          if (is_mem(w_opcode) || is_alu(w_opcode) || w_opcode == OP_BR)
            r_state <= S_E3;
          else if (w_opcode == OP_HALT)
            r_state <= S_HALT;
          else
            r_state <= S_T0;
        end
        S_E3: r_state <= S_E4;
        S_E4: r_state <= S_E5;
        S_E5: r_state <= (is_alu(w_opcode) || w_opcode == OP_LDI) ? S_T0 : S_E6;
        S_E6: r_state <= (w_opcode == OP_BR) ? S_T0 : S_E7;
        S_E7: r_state <= (w_opcode == OP_ST) ? S_T0 : S_E8;
        S_E8: r_state <= S_T0;
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  mini_src_ctrl_decode u_decode (
    .i_state  (r_state),
    .i_opcode (w_opcode),
    .i_con_ff (con_ff),
    .o_ctrl_c (w_ctrl)
  );

  assign incPC         = w_ctrl.inc_pc;
  assign e_PC          = w_ctrl.e_pc;
  assign e_IR          = w_ctrl.e_ir;
  assign e_Y           = w_ctrl.e_y;
  assign e_Z           = w_ctrl.e_z;
  assign e_MDR         = w_ctrl.e_mdr;
  assign e_MAR         = w_ctrl.e_mar;
  assign e_CON_FF      = w_ctrl.e_con_ff;
  assign ram_read      = w_ctrl.ram_read;
  assign ram_write     = w_ctrl.ram_write;
  assign MDR_read      = w_ctrl.mdr_read;
  assign ALU_op        = w_ctrl.alu_op;
  assign BusDataSelect = w_ctrl.bus_sel;
  assign Gra           = w_ctrl.gra;
  assign Grb           = w_ctrl.grb;
  assign Grc           = w_ctrl.grc;
  assign e_Rin         = w_ctrl.e_rin;
  assign e_Rout        = w_ctrl.e_rout;
  assign BAout         = w_ctrl.ba_out;
  assign imm_sel       = w_ctrl.imm_sel;
  assign halted        = w_ctrl.halted;
  assign illegal       = w_ctrl.illegal;

  assign e_HI      = 1'b0;
  assign e_LO      = 1'b0;
  assign e_RA      = 1'b0;
  assign e_GP      = 1'b0;
  assign e_OutPort = 1'b0;
  assign e_InPort  = 1'b0;

endmodule
